// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM condition codes and NZCV flag bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: pass from cond against NZCV; zero latency, no handshake.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags[FLAG_N];
  assign w_z = flags[FLAG_Z];
  assign w_c = flags[FLAG_C];
  assign w_v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !w_c || w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = w_z || (w_n != w_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Conditional-execute stage: 1-cycle registered result, NZCV updated on pass && setflags; in_ready = !out_valid || out_ready.
// Build option COND_STATS_EN adds stat_exec/stat_skip accept counters.
module cond_exec_stage
  import cpu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_cond,
  input  logic         in_setflags,
  input  logic [3:0]   in_flags,
  input  logic [N-1:0] in_data,
  input  logic         flags_we,
  input  logic [3:0]   flags_wdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_exec,
  output logic [N-1:0] out_data,
  output logic [3:0]   flags
`ifdef COND_STATS_EN
  ,
  output logic [31:0]  stat_exec,
  output logic [31:0]  stat_skip
`endif
);

  logic         r_out_valid;
  logic         r_out_exec;
  logic [N-1:0] r_out_data;
  logic [3:0]   r_flags;

  logic w_in_ready;
  logic w_accept;
  logic w_pass;

  // Condition sees the architectural register, so a flag write accepted last
  // cycle is already visible here without a bubble.
  cond_check u_cond_check (
    .cond  (in_cond),
    .flags (r_flags),
    .pass  (w_pass)
  );

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_exec  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_exec  <= w_pass;
      r_out_data  <= in_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Direct write wins over an instruction update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (flags_we) begin
      r_flags <= flags_wdata;
    end else if (w_accept && w_pass && in_setflags) begin
      r_flags <= in_flags;
    end
  end

`ifdef COND_STATS_EN
  logic [31:0] r_stat_exec;
  logic [31:0] r_stat_skip;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_exec <= '0;
      r_stat_skip <= '0;
    end else if (w_accept) begin
      if (w_pass) r_stat_exec <= r_stat_exec + 32'd1;
      else        r_stat_skip <= r_stat_skip + 32'd1;
    end
  end

  assign stat_exec = r_stat_exec;
  assign stat_skip = r_stat_skip;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_exec  = r_out_exec;
  assign out_data  = r_out_data;
  assign flags     = r_flags;

endmodule
